// File: rtl/bus_pkg.sv
// Shared 68000 bus-side types: decoded region, acknowledge FSM states and
// default wait-state constants used by the acknowledge generators.
package bus_pkg;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_ROM,
    REG_RAM,
    REG_DRAM,
    REG_IO,
    REG_CAN
  } region_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    EXT,
    ACK,
    ERR
  } dtack_state_t;

  localparam int ROM_WAIT_DEF = 1;
  localparam int RAM_WAIT_DEF = 0;
  localparam int IO_WAIT_DEF  = 2;
  localparam int TIMEOUT_DEF  = 255;
  localparam int CNT_W_DEF    = 8;

  // Overlapping decoder selects resolve as ROM > RAM > DRAM > IO > CAN.
  function automatic region_t decode_region(input logic rom, input logic ram,
                                            input logic dram, input logic io,
                                            input logic can);
    if (rom)       return REG_ROM;
    else if (ram)  return REG_RAM;
    else if (dram) return REG_DRAM;
    else if (io)   return REG_IO;
    else if (can)  return REG_CAN;
    else           return REG_NONE;
  endfunction

endpackage

// File: rtl/cycle_timeout_counter.sv
// Bus-cycle watchdog: counts enabled clocks since the last clear. o_terminal
// is high on the enabled clock whose edge brings the count to TIMEOUT.
module cycle_timeout_counter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TOP  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != TOP)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_terminal = i_en && (r_count == LAST);

endmodule

// File: rtl/dtack_wait_state_generator.sv
// Generates 68000 DTACK_L/BERR_L from decoder selects: fixed wait states for
// on-chip regions, forwarded acks for DRAM/CAN, bus error on timeout.
module dtack_wait_state_generator
  import bus_pkg::*;
#(
  parameter int ROM_WAIT = ROM_WAIT_DEF,
  parameter int RAM_WAIT = RAM_WAIT_DEF,
  parameter int IO_WAIT  = IO_WAIT_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic Clk,
  input  logic Reset_H,
  input  logic AS_L,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic DramSelect_H,
  input  logic IOSelect_H,
  input  logic CanBusSelect_H,
  input  logic DramDtack_L,
  input  logic CanBusDtack_L,
  output logic DTACK_L,
  output logic BERR_L,
  output logic Busy_H
);

  dtack_state_t     r_state;
  region_t          r_region;
  logic [CNT_W-1:0] r_wait;
  logic             r_dtack_l;
  logic             r_berr_l;
  logic             r_busy;

  region_t          w_sel_region;
  logic [CNT_W-1:0] w_load_wait;
  logic             w_onchip;
  logic             w_start;
  logic             w_ext_ack;
  logic             w_timeout;
  logic             w_cnt_en;
  logic             w_cnt_clr;

  assign w_sel_region = decode_region(OnChipRomSelect_H, OnChipRamSelect_H,
                                      DramSelect_H, IOSelect_H, CanBusSelect_H);
  assign w_start      = (r_state == IDLE) && !AS_L && (!UDS_L || !LDS_L);
  assign w_ext_ack    = ((r_region == REG_DRAM) && !DramDtack_L) ||
                        ((r_region == REG_CAN)  && !CanBusDtack_L);
  assign w_cnt_en     = (r_state == WAIT) || (r_state == EXT);
  assign w_cnt_clr    = (r_state == IDLE);

  always_comb begin
    w_load_wait = '0;
    w_onchip    = 1'b0;
    case (w_sel_region)
      REG_ROM: begin w_load_wait = CNT_W'(ROM_WAIT); w_onchip = 1'b1; end
      REG_RAM: begin w_load_wait = CNT_W'(RAM_WAIT); w_onchip = 1'b1; end
      REG_IO:  begin w_load_wait = CNT_W'(IO_WAIT);  w_onchip = 1'b1; end
      default: begin w_load_wait = '0;               w_onchip = 1'b0; end
    endcase
  end

  cycle_timeout_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk      (Clk),
    .i_rst      (Reset_H),
    .i_clr      (w_cnt_clr),
    .i_en       (w_cnt_en),
    .o_terminal (w_timeout)
  );

  // Strobes are registered one edge after ACK/ERR is entered, so every
  // response appears the clock after its triggering condition was sampled.
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      r_state   <= IDLE;
      r_region  <= REG_NONE;
      r_wait    <= '0;
      r_dtack_l <= 1'b1;
      r_berr_l  <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_dtack_l <= 1'b1;
          r_berr_l  <= 1'b1;
          if (w_start) begin
            r_region <= w_sel_region;
            r_busy   <= 1'b1;
            r_wait   <= w_load_wait;
            if (!w_onchip)               r_state <= EXT;
            else if (w_load_wait == '0)  r_state <= ACK;
            else                         r_state <= WAIT;
          end
        end
        WAIT: begin
          if (AS_L) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_wait  <= '0;
          end else if (w_timeout) begin
            r_state <= ERR;
          end else if (r_wait == CNT_W'(1)) begin
            r_state <= ACK;
            r_wait  <= '0;
          end else begin
            r_wait  <= r_wait - CNT_W'(1);
          end
        end
        EXT: begin
          if (AS_L) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_timeout) begin
            r_state <= ERR;
          end else if (w_ext_ack) begin
            r_state <= ACK;
          end
        end
        ACK: begin
          if (AS_L) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_dtack_l <= 1'b1;
          end else begin
            r_dtack_l <= 1'b0;
          end
        end
        ERR: begin
          if (AS_L) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_berr_l <= 1'b1;
          end else begin
            r_berr_l <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_dtack_l <= 1'b1;
          r_berr_l  <= 1'b1;
        end
      endcase
    end
  end

  assign DTACK_L = r_dtack_l;
  assign BERR_L  = r_berr_l;
  assign Busy_H  = r_busy;

endmodule

// File: tb/tb_dtack_wait_state_generator.sv
// Scoreboard bench: the driver predicts each bus cycle's response from the
// timing rules and queues it; a monitor matches every DTACK/BERR assertion.
module tb_dtack_wait_state_generator;

  localparam int ROM_W = 1;
  localparam int RAM_W = 0;
  localparam int IO_W  = 2;
  localparam int TMO   = 255;
  localparam int NEVER = 100000;

  logic Clk, Reset_H, AS_L, UDS_L, LDS_L;
  logic OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H, IOSelect_H, CanBusSelect_H;
  logic DramDtack_L, CanBusDtack_L;
  logic DTACK_L, BERR_L, Busy_H;

  dtack_wait_state_generator #(
    .ROM_WAIT (ROM_W),
    .RAM_WAIT (RAM_W),
    .IO_WAIT  (IO_W),
    .TIMEOUT  (TMO),
    .CNT_W    (8)
  ) dut (
    .Clk               (Clk),
    .Reset_H           (Reset_H),
    .AS_L              (AS_L),
    .UDS_L             (UDS_L),
    .LDS_L             (LDS_L),
    .OnChipRomSelect_H (OnChipRomSelect_H),
    .OnChipRamSelect_H (OnChipRamSelect_H),
    .DramSelect_H      (DramSelect_H),
    .IOSelect_H        (IOSelect_H),
    .CanBusSelect_H    (CanBusSelect_H),
    .DramDtack_L       (DramDtack_L),
    .CanBusDtack_L     (CanBusDtack_L),
    .DTACK_L           (DTACK_L),
    .BERR_L            (BERR_L),
    .Busy_H            (Busy_H)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int edge_cnt = 0;
  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    bit is_berr;
    int edge_no;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   txn_no = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endfunction

  // Reference timing: region index 0..4 = ROM,RAM,DRAM,IO,CAN, 5 = unmapped.
  // kind 0 = nothing, 1 = DTACK, 2 = BERR; lat = clocks from start edge.
  function automatic void predict(input int reg_i, input int d, input int a,
                                  output int kind, output int lat);
    int waits[5];
    waits = '{ROM_W, RAM_W, 0, IO_W, 0};
    if (reg_i == 0 || reg_i == 1 || reg_i == 3) begin
      kind = 1; lat = waits[reg_i] + 1;
    end else if ((reg_i == 2 || reg_i == 4) && d < TMO) begin
      kind = 1; lat = d + 1;
    end else begin
      kind = 2; lat = TMO + 1;
    end
    if (a != 0 && a <= lat) kind = 0;
  endfunction

  // Monitor: every falling DTACK_L/BERR_L must match the head of the queue.
  logic prev_d = 1'b1, prev_b = 1'b1;
  bit   fell_d, fell_b;
  exp_t mon_e;
  always @(negedge Clk) begin
    fell_d = (prev_d === 1'b1) && (DTACK_L === 1'b0);
    fell_b = (prev_b === 1'b1) && (BERR_L === 1'b0);
    if (DTACK_L === 1'b0 || BERR_L === 1'b0)
      check("exclusive_strobes", {31'b0, DTACK_L | BERR_L}, 32'd1);
    if (fell_d || fell_b) begin
      if (sb_q.size() == 0) begin
        check("spurious_strobe", {30'b0, fell_b, fell_d}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("strobe_is_berr", {31'b0, fell_b}, {31'b0, mon_e.is_berr});
        check("strobe_edge", edge_cnt, mon_e.edge_no);
      end
    end else if (sb_q.size() > 0 && edge_cnt > sb_q[0].edge_no) begin
      check("missed_strobe_edge", edge_cnt, sb_q[0].edge_no);
      void'(sb_q.pop_front());
    end
    prev_d = DTACK_L;
    prev_b = BERR_L;
  end

  task automatic idle_inputs();
    AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    {CanBusSelect_H, IOSelect_H, DramSelect_H, OnChipRamSelect_H, OnChipRomSelect_H} = 5'b0;
    DramDtack_L = 1'b1; CanBusDtack_L = 1'b1;
  endtask

  // sel bits [0..4] = ROM,RAM,DRAM,IO,CAN; d = offset of first low ext ack;
  // a = abort offset (0 = none); h = clocks the strobe is held before AS_L rises.
  task automatic run_txn(input logic [4:0] sel, input int d, input int a, input int h);
    int reg_i, kind, lat, r, start, strb;
    exp_t e;
    reg_i = 5;
    for (int i = 0; i < 5; i++) if (sel[i] && reg_i == 5) reg_i = i;
    predict(reg_i, d, a, kind, lat);
    r = (kind == 0) ? a : lat + h;
    @(negedge Clk);
    {CanBusSelect_H, IOSelect_H, DramSelect_H, OnChipRamSelect_H, OnChipRomSelect_H} = sel;
    strb  = $urandom_range(0, 2);
    UDS_L = (strb == 1);
    LDS_L = (strb == 2);
    AS_L  = 1'b0;
    start = edge_cnt + 1;
    if (kind != 0) begin
      e.is_berr = (kind == 2);
      e.edge_no = start + lat;
      sb_q.push_back(e);
    end
    for (int k = 1; k <= r; k++) begin
      @(negedge Clk);
      if (k == 1) check("busy_in_cycle", {31'b0, Busy_H}, 32'd1);
      {CanBusSelect_H, IOSelect_H, DramSelect_H, OnChipRamSelect_H, OnChipRomSelect_H} = 5'($urandom);
      DramDtack_L   = (reg_i == 2) ? (k < d) : 1'($urandom_range(0, 1));
      CanBusDtack_L = (reg_i == 4) ? (k < d) : 1'($urandom_range(0, 1));
      if (k == r) begin
        AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
        DramDtack_L = 1'b1; CanBusDtack_L = 1'b1;
      end
    end
    @(negedge Clk);
    check("release_dtack", {31'b0, DTACK_L}, 32'd1);
    check("release_berr", {31'b0, BERR_L}, 32'd1);
    check("release_busy", {31'b0, Busy_H}, 32'd0);
    txn_no++;
    $display("txn %0d sel=%b region=%0d kind=%0d lat=%0d abort=%0d start=%0d",
             txn_no, sel, reg_i, kind, lat, a, start);
  endtask

  // DRAM cycle with reset pulsed at offset rst_at; ack first low at ack_at.
  task automatic reset_during(input int ack_at, input int rst_at);
    int start;
    exp_t e;
    @(negedge Clk);
    {CanBusSelect_H, IOSelect_H, DramSelect_H, OnChipRamSelect_H, OnChipRomSelect_H} = 5'b00100;
    AS_L = 1'b0; LDS_L = 1'b0; UDS_L = 1'b0;
    start = edge_cnt + 1;
    if (ack_at + 1 < rst_at) begin
      e.is_berr = 1'b0;
      e.edge_no = start + ack_at + 1;
      sb_q.push_back(e);
    end
    for (int k = 1; k <= rst_at; k++) begin
      @(negedge Clk);
      DramDtack_L = (k < ack_at);
      if (k == rst_at) begin
        Reset_H = 1'b1;
        idle_inputs();
      end
    end
    @(negedge Clk);
    check("reset_dtack", {31'b0, DTACK_L}, 32'd1);
    check("reset_berr", {31'b0, BERR_L}, 32'd1);
    check("reset_busy", {31'b0, Busy_H}, 32'd0);
    Reset_H = 1'b0;
    txn_no++;
    $display("txn %0d reset pulse ack_at=%0d rst_at=%0d start=%0d", txn_no, ack_at, rst_at, start);
  endtask

  initial begin
    logic [4:0] sel;
    int d, a, h;
    Reset_H = 1'b1;
    idle_inputs();
    repeat (3) @(negedge Clk);
    check("reset_dtack", {31'b0, DTACK_L}, 32'd1);
    check("reset_berr", {31'b0, BERR_L}, 32'd1);
    check("reset_busy", {31'b0, Busy_H}, 32'd0);
    Reset_H = 1'b0;

    run_txn(5'b00001, NEVER, 0, 2);   // ROM: DTACK at +2
    run_txn(5'b00010, NEVER, 0, 1);   // RAM: DTACK at +1
    run_txn(5'b00011, NEVER, 0, 1);   // ROM wins over RAM
    run_txn(5'b00100, 6, 0, 2);       // DRAM ack after 5 high clocks, CAN noise
    run_txn(5'b10000, 3, 0, 1);       // CAN forwarded ack
    run_txn(5'b00000, NEVER, 0, 2);   // unmapped: BERR at +256
    run_txn(5'b01000, NEVER, 1, 0);   // IO aborted one clock in
    run_txn(5'b01000, NEVER, 0, 1);   // IO: DTACK at +3
    run_txn(5'b00100, NEVER, 0, 1);   // DRAM never acks: BERR
    reset_during(2, 5);               // reset while in ACK
    reset_during(NEVER, 4);           // reset while in EXT
    run_txn(5'b00001, NEVER, 0, 1);

    for (int n = 0; n < 40; n++) begin
      sel = 5'($urandom_range(0, 31));
      if (sel == 5'b0 && $urandom_range(0, 3) != 0) sel = 5'b00100;
      d = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, 8);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      h = $urandom_range(1, 3);
      run_txn(sel, d, a, h);
    end

    repeat (5) @(negedge Clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
